mem_dump_ctrl: RTL and testbench

MEM_DUMP_CTRL -- requirements
Module: mem_dump_ctrl

---
 rtl/mem_dump_ctrl.sv | 151 +++++++++++++++
 tb/tb_mem_dump_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_dump_ctrl.sv
// mem_dump_ctrl: walks a data memory one word at a time and streams each word
// out as a valid/ready beat tagged with its index.
//
// Ports:
//   CLOCK_50  - sole clock; all state changes on its rising edge
//   reset     - asynchronous active-high reset
//   dump      - dump request; a dump starts on its 0->1 transition
//   rd_en     - memory read strobe (high only in READ)
//   rd_addr   - memory word index (0 whenever rd_en is low)
//   rd_data   - memory read data, valid one cycle after rd_en
//   out_valid - dump beat valid (high only in SEND)
//   out_ready - consumer ready
//   out_addr  - word index of the current beat
//   out_data  - word value of the current beat
//   busy      - high in every state except IDLE
//   done      - one-cycle pulse at the end of a dump
//   word_cnt  - beats accepted in the current or last dump
//
// Build option: define DUMP_SKIP_ZERO_EN to drop all-zero words from the
// dump (no beat and no word_cnt increment for them).
module mem_dump_ctrl #(
  parameter int N     = 64,
  parameter int DEPTH = 32
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     dump,
  output logic                     rd_en,
  output logic [$clog2(DEPTH)-1:0] rd_addr,
  input  logic [N-1:0]             rd_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH)-1:0] out_addr,
  output logic [N-1:0]             out_data,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   word_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic          dump_q;
  logic [AW-1:0] idx;
  logic          start_clr;
  logic          capture;
  logic          idx_adv;
  logic          cnt_inc;
  logic          last;

  assign last = (idx == LAST_IDX);

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = '0;
    out_valid = 1'b0;
    busy      = (state != IDLE);
    done      = 1'b0;
    start_clr = 1'b0;
    capture   = 1'b0;
    idx_adv   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      IDLE: begin
        if (dump && !dump_q) begin
          start_clr = 1'b1;
          state_nxt = READ;
        end
      end
      READ: begin
        rd_en     = 1'b1;
        rd_addr   = idx;
        state_nxt = CAPTURE;
      end
      CAPTURE: begin
        capture = 1'b1;
`ifdef DUMP_SKIP_ZERO_EN
        // All-zero words skip SEND but still advance the index.
        if (rd_data == '0) begin
          if (last) begin
            state_nxt = DONE;
          end else begin
            idx_adv   = 1'b1;
            state_nxt = READ;
          end
        end else begin
          state_nxt = SEND;
        end
`else
        state_nxt = SEND;
`endif
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_inc = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end else begin
            idx_adv   = 1'b1;
            state_nxt = READ;
          end
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      dump_q   <= 1'b0;
      idx      <= '0;
      word_cnt <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      state  <= state_nxt;
      dump_q <= dump;
      if (start_clr) begin
        idx      <= '0;
        word_cnt <= '0;
      end
      if (idx_adv) begin
        idx <= idx + AW'(1);
      end
      if (cnt_inc) begin
        word_cnt <= word_cnt + (AW + 1)'(1);
      end
      if (capture) begin
        out_data <= rd_data;
        out_addr <= idx;
      end
    end
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
module tb_mem_dump_ctrl;
  localparam int N     = 64;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          CLOCK_50 = 1'b0;
  logic          reset;
  logic          dump;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [N-1:0]  out_data;
  logic          busy;
  logic          done;
  logic [AW:0]   word_cnt;

  mem_dump_ctrl #(.N(N), .DEPTH(DEPTH)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .dump     (dump),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_addr (out_addr),
    .out_data (out_data),
    .busy     (busy),
    .done     (done),
    .word_cnt (word_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [N-1:0]  data;
  } beat_t;

  beat_t        exp_q[$];
  logic [N-1:0] mem[DEPTH];
  int           errors    = 0;
  int           checks    = 0;
  int           done_seen = 0;
  int           done_exp  = 0;

  // Synchronous-read memory model: data appears the cycle after rd_en.
  always @(posedge CLOCK_50) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      if (done) done_seen++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {62'd0, out_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat_addr", {62'd0, out_addr}, {62'd0, e.addr});
          chk("beat_data", out_data, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic push_dump();
    for (int i = 0; i < DEPTH; i++) begin
`ifdef DUMP_SKIP_ZERO_EN
      if (mem[i] == '0) continue;
`endif
      exp_q.push_back({AW'(i), mem[i]});
    end
  endtask

  // Leaves dump high; the FSM is in READ on return.
  task automatic start_dump();
    push_dump();
    dump = 1'b0;
    tick();
    dump = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    if (!out_valid) chk({name, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_done(input string name, input int exp_cnt);
    int n = 0;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!done && n < 200);
    if (!done) begin
      chk({name, "_done_timeout"}, 64'd0, 64'd1);
    end else begin
      done_exp++;
      chk({name, "_word_cnt"}, 64'(word_cnt), 64'(exp_cnt));
      @(negedge CLOCK_50);
      chk({name, "_done_one_cycle"}, 64'(done), 64'd0);
      chk({name, "_busy_after"}, 64'(busy), 64'd0);
      chk({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
    end
  endtask

  task automatic reset_outputs_zero(input string name);
    chk({name, "_rd_en"}, 64'(rd_en), 64'd0);
    chk({name, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({name, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({name, "_out_addr"}, 64'(out_addr), 64'd0);
    chk({name, "_out_data"}, out_data, 64'd0);
    chk({name, "_busy"}, 64'(busy), 64'd0);
    chk({name, "_done"}, 64'(done), 64'd0);
    chk({name, "_word_cnt"}, 64'(word_cnt), 64'd0);
  endtask

  // Accept the currently presented beat with a single-cycle ready pulse.
  task automatic accept_one();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    dump      = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 64'(i + 1);

    // Reset state
    #12;
    reset_outputs_zero("reset");
    #8;
    reset = 1'b0;
    tick();

    // Basic dump with fixed first-beat latency
    out_ready = 1'b1;
    push_dump();
    dump = 1'b0;
    tick();
    dump = 1'b1;
    @(posedge CLOCK_50);              // start detected here (edge k)
    @(negedge CLOCK_50);
    chk("lat_rd_en_k1", 64'(rd_en), 64'd1);
    chk("lat_rd_addr_k1", 64'(rd_addr), 64'd0);
    chk("lat_busy_k1", 64'(busy), 64'd1);
    chk("lat_word_cnt_clr", 64'(word_cnt), 64'd0);
    @(negedge CLOCK_50);
    chk("lat_rd_en_k2", 64'(rd_en), 64'd0);
    chk("lat_valid_k2", 64'(out_valid), 64'd0);
    @(negedge CLOCK_50);
    chk("lat_valid_k3", 64'(out_valid), 64'd1);
    wait_done("basic", 4);

    // Held request: dump stays high through DONE
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("held_no_restart", 64'(busy), 64'd0);
    end
    push_dump();
    dump = 1'b0;
    tick();
    dump = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("restart_rd_en", 64'(rd_en), 64'd1);
    chk("restart_rd_addr", 64'(rd_addr), 64'd0);
    chk("restart_word_cnt", 64'(word_cnt), 64'd0);
    wait_done("restart", 4);

    // Backpressure at beat addr 1
    tick();
    out_ready = 1'b0;
    start_dump();
    wait_valid("bp_beat0");
    accept_one();
    wait_valid("bp_beat1");
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid_held", 64'(out_valid), 64'd1);
      chk("bp_addr_held", 64'(out_addr), 64'd1);
      chk("bp_data_held", out_data, 64'd2);
      tick();
    end
    out_ready = 1'b1;
    wait_done("backpressure", 4);

    // Reset in the middle of a dump, at beat addr 2
    tick();
    out_ready = 1'b0;
    start_dump();
    wait_valid("rst_beat0");
    accept_one();
    wait_valid("rst_beat1");
    accept_one();
    wait_valid("rst_beat2");
    chk("rst_at_addr2", 64'(out_addr), 64'd2);
    reset = 1'b1;
    #1;
    reset_outputs_zero("midreset");
    exp_q.delete();
    tick();
    reset = 1'b0;
    tick();
    out_ready = 1'b1;
    start_dump();
    wait_done("after_reset", 4);

    // Zero words in memory
    mem[0] = 64'd5;
    mem[1] = 64'd0;
    mem[2] = 64'd0;
    mem[3] = 64'd7;
    tick();
    start_dump();
`ifdef DUMP_SKIP_ZERO_EN
    wait_done("skip_zero", 2);
`else
    wait_done("skip_zero", 4);
`endif

    repeat (3) tick();
    chk("done_pulse_count", 64'(done_seen), 64'(done_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
